// File: rtl/raifes_uart_tx.sv
// raifes_uart_tx: FIFO-buffered UART transmitter with configurable framing.
// Ports:
//   clk, reset          - system clock, synchronous active-high reset
//   sdata, send_strobe  - byte to enqueue and its one-cycle write request
//   ready               - FIFO can accept a write this cycle
//   busy                - frame on the line or FIFO non-empty
//   fifo_level          - current FIFO occupancy
//   overflow            - one-cycle pulse when a strobe is dropped
//   UART_TX             - serial line, idle high
module raifes_uart_tx #(
  parameter int unsigned CLK_DIV    = 5208,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          sdata,
  input  logic                          send_strobe,
  output logic                          ready,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          UART_TX
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = 16;
  localparam int unsigned BW = 3;

  localparam logic [CW-1:0] RELOAD    = CW'(CLK_DIV - 1);
  localparam logic [LW-1:0] FULL      = LW'(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic          PAR_ODD   = (PARITY == 2);
  localparam logic          HAS_PAR   = (PARITY != 0);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_t;

  state_t                 state;
  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [CW-1:0]          bit_cnt;
  logic [BW-1:0]          bit_idx;
  logic                   stop_idx;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_bit;

  logic                   wr_en;
  logic                   pop;
  logic                   bit_end;
  logic                   frame_done;
  logic                   in_frame;
  logic [LW-1:0]          level_next;

  // Write/pop decisions and next FIFO occupancy
  always_comb begin
    wr_en      = send_strobe && ready;
    bit_end    = (bit_cnt == '0);
    frame_done = (state == STOP) && bit_end && (stop_idx == LAST_STOP);
    pop        = (fifo_level != '0) && ((state == IDLE) || frame_done);
    in_frame   = (state == START) || (state == DATA) || (state == PAR) || (state == STOP);
    level_next = fifo_level;
    if (wr_en && !pop) begin
      level_next = fifo_level + LW'(1);
    end else if (!wr_en && pop) begin
      level_next = fifo_level - LW'(1);
    end
  end

  // FIFO storage; stale contents are harmless since occupancy is reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= sdata;
    end
  end

  // FIFO control, status outputs and transmit state machine
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      UART_TX    <= 1'b1;
      fifo_level <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ready      <= 1'b1;
      busy       <= 1'b0;
      overflow   <= 1'b0;
      bit_cnt    <= RELOAD;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shreg      <= '0;
      par_bit    <= 1'b0;
    end else begin
      overflow   <= send_strobe && !ready;
      fifo_level <= level_next;
      ready      <= (level_next != FULL);
      busy       <= (level_next != '0) || pop || (in_frame && !frame_done);

      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      // Parity is captured with the byte so the PAR state needs no extra logic
      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        shreg   <= mem[rd_ptr];
        par_bit <= (^mem[rd_ptr]) ^ PAR_ODD;
      end

      case (state)
        IDLE: begin
          UART_TX <= 1'b1;
          bit_cnt <= RELOAD;
          if (pop) begin
            state   <= START;
            UART_TX <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            bit_cnt <= RELOAD;
            state   <= DATA;
            UART_TX <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= '0;
          end else begin
            bit_cnt <= bit_cnt - CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            bit_cnt <= RELOAD;
            if (bit_idx == LAST_DATA) begin
              if (HAS_PAR) begin
                state   <= PAR;
                UART_TX <= par_bit;
              end else begin
                state    <= STOP;
                UART_TX  <= 1'b1;
                stop_idx <= 1'b0;
              end
            end else begin
              UART_TX <= shreg[0];
              shreg   <= shreg >> 1;
              bit_idx <= bit_idx + BW'(1);
            end
          end else begin
            bit_cnt <= bit_cnt - CW'(1);
          end
        end
        PAR: begin
          if (bit_end) begin
            bit_cnt  <= RELOAD;
            state    <= STOP;
            UART_TX  <= 1'b1;
            stop_idx <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt - CW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            bit_cnt <= RELOAD;
            if (stop_idx == LAST_STOP) begin
              // Chain straight into the next frame when data is waiting
              if (pop) begin
                state   <= START;
                UART_TX <= 1'b0;
              end else begin
                state   <= IDLE;
                UART_TX <= 1'b1;
              end
            end else begin
              stop_idx <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt - CW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          UART_TX <= 1'b1;
          bit_cnt <= RELOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_raifes_uart_tx.sv
// tb_raifes_uart_tx: four transmitter configurations (8N1, 8E1, 8O1, 5N2),
// all at CLK_DIV=4 and FIFO_DEPTH=4, checked against a frame-level model.
module tb_raifes_uart_tx;

  localparam int NI    = 4;
  localparam int CD    = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sd  [NI];
  logic       stb [NI];
  logic       txl [NI];
  logic       rdy [NI];
  logic       bsy [NI];
  logic       ovf [NI];
  logic [2:0] lvl [NI];

  // Snapshot per cycle: {tx, busy, ready, overflow, level[2:0]}
  logic [6:0] cap[$];
  logic [6:0] exp_q[$];
  int         sched_w[$];
  logic [7:0] sched_v[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  raifes_uart_tx #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u0 (
    .clk(clk), .reset(reset), .sdata(sd[0]), .send_strobe(stb[0]), .ready(rdy[0]),
    .busy(bsy[0]), .fifo_level(lvl[0]), .overflow(ovf[0]), .UART_TX(txl[0]));
  raifes_uart_tx #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u1 (
    .clk(clk), .reset(reset), .sdata(sd[1]), .send_strobe(stb[1]), .ready(rdy[1]),
    .busy(bsy[1]), .fifo_level(lvl[1]), .overflow(ovf[1]), .UART_TX(txl[1]));
  raifes_uart_tx #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u2 (
    .clk(clk), .reset(reset), .sdata(sd[2]), .send_strobe(stb[2]), .ready(rdy[2]),
    .busy(bsy[2]), .fifo_level(lvl[2]), .overflow(ovf[2]), .UART_TX(txl[2]));
  raifes_uart_tx #(.CLK_DIV(CD), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u3 (
    .clk(clk), .reset(reset), .sdata(sd[3][4:0]), .send_strobe(stb[3]), .ready(rdy[3]),
    .busy(bsy[3]), .fifo_level(lvl[3]), .overflow(ovf[3]), .UART_TX(txl[3]));

  function automatic int db(input int i);
    return (i == 3) ? 5 : 8;
  endfunction
  function automatic int par(input int i);
    return (i == 1) ? 1 : (i == 2) ? 2 : 0;
  endfunction
  function automatic int sb(input int i);
    return (i == 3) ? 2 : 1;
  endfunction

  // Bit k of the frame carrying byte v on instance i
  function automatic logic frame_bit(input int i, input logic [7:0] v, input int k);
    logic [7:0] m;
    m = 8'h00;
    for (int j = 0; j < db(i); j++) m[j] = v[j];
    if (k == 0) return 1'b0;
    if (k <= db(i)) return m[k-1];
    if (par(i) != 0 && k == db(i) + 1) return (^m) ^ (par(i) == 2);
    return 1'b1;
  endfunction

  // Frame-level model: each accepted byte starts at max(previous end, write+1)
  task automatic model(input int i, input int n);
    int L, occ, s, prev_end;
    int aw[$];
    int as[$];
    logic [7:0] av[$];
    int dropped[$];
    logic tx, act, o;
    L = CD * (1 + db(i) + ((par(i) != 0) ? 1 : 0) + sb(i));
    prev_end = -1000;
    exp_q.delete();
    foreach (sched_w[j]) begin
      occ = 0;
      foreach (aw[q]) begin
        if (aw[q] <= sched_w[j] - 1) occ++;
        if (as[q] <= sched_w[j] - 1) occ--;
      end
      if (occ < DEPTH) begin
        s = (prev_end > sched_w[j] + 1) ? prev_end : sched_w[j] + 1;
        prev_end = s + L;
        aw.push_back(sched_w[j]);
        as.push_back(s);
        av.push_back(sched_v[j]);
      end else begin
        dropped.push_back(sched_w[j]);
      end
    end
    for (int e = 0; e < n; e++) begin
      tx = 1'b1; act = 1'b0; occ = 0; o = 1'b0;
      foreach (aw[q]) begin
        if (aw[q] <= e) occ++;
        if (as[q] <= e) occ--;
        if (as[q] <= e && e < as[q] + L) begin
          tx  = frame_bit(i, av[q], (e - as[q]) / CD);
          act = 1'b1;
        end
      end
      foreach (dropped[q]) if (dropped[q] == e) o = 1'b1;
      exp_q.push_back({tx, (occ > 0) || act, occ != DEPTH, o, 3'(occ)});
    end
  endtask

  // Drive scheduled writes on instance i and record n post-edge snapshots
  task automatic run(input int i, input int n);
    cap.delete();
    for (int t = 0; t < n; t++) begin
      stb[i] = 1'b0;
      foreach (sched_w[j]) if (sched_w[j] == t) begin
        stb[i] = 1'b1;
        sd[i]  = sched_v[j];
      end
      @(posedge clk);
      @(negedge clk);
      cap.push_back({txl[i], bsy[i], rdy[i], ovf[i], lvl[i]});
    end
    stb[i] = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    for (int i = 0; i < NI; i++) begin
      stb[i] = 1'b0;
      sd[i]  = 8'h00;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      n_cmp++;
      if ({txl[i], bsy[i], rdy[i], ovf[i], lvl[i]} !== 7'b1010000) begin
        n_bad++;
        $display("FAIL reset inst=%0d got %b want 1010000", i, {txl[i], bsy[i], rdy[i], ovf[i], lvl[i]});
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_single_byte;
    logic [9:0] seq;
    seq = 10'b1101001010;
    sched_w = '{0};
    sched_v = '{8'hA5};
    model(0, 50);
    run(0, 50);
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < CD; c++) begin
        n_cmp++;
        if (cap[1 + b*CD + c][6] !== seq[b]) begin
          n_bad++;
          $display("FAIL single_bit b=%0d c=%0d got %b want %b", b, c, cap[1 + b*CD + c][6], seq[b]);
        end
      end
    end
    n_cmp++;
    if (cap[40][5] !== 1'b1 || cap[41][5] !== 1'b0) begin
      n_bad++;
      $display("FAIL single_busy got %b%b want 10", cap[40][5], cap[41][5]);
    end
    for (int e = 0; e < 50; e++) begin
      n_cmp++;
      if (cap[e] !== exp_q[e]) begin
        n_bad++;
        $display("FAIL single e=%0d got %b want %b", e, cap[e], exp_q[e]);
      end
    end
  endtask

  task automatic test_parity;
    for (int i = 1; i <= 2; i++) begin
      sched_w = '{0};
      sched_v = '{8'h07};
      model(i, 55);
      run(i, 55);
      n_cmp++;
      if (cap[1 + 9*CD][6] !== ((i == 1) ? 1'b1 : 1'b0)) begin
        n_bad++;
        $display("FAIL parity_bit inst=%0d got %b want %b", i, cap[1 + 9*CD][6], (i == 1));
      end
      n_cmp++;
      if (cap[44][5] !== 1'b1 || cap[45][5] !== 1'b0) begin
        n_bad++;
        $display("FAIL parity_len inst=%0d got %b%b want 10", i, cap[44][5], cap[45][5]);
      end
      for (int e = 0; e < 55; e++) begin
        n_cmp++;
        if (cap[e] !== exp_q[e]) begin
          n_bad++;
          $display("FAIL parity inst=%0d e=%0d got %b want %b", i, e, cap[e], exp_q[e]);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    int ovf_cnt;
    sched_w = '{0, 1, 2, 3, 4};
    sched_v = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    model(0, 215);
    run(0, 215);
    ovf_cnt = 0;
    for (int e = 0; e < 215; e++) if (cap[e][3] === 1'b1) ovf_cnt++;
    n_cmp++;
    if (ovf_cnt !== 0) begin
      n_bad++;
      $display("FAIL b2b_overflow got %0d want 0", ovf_cnt);
    end
    n_cmp++;
    if (cap[41][6] !== 1'b0 || cap[201][5] !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_gap got tx41=%b busy201=%b want 0 0", cap[41][6], cap[201][5]);
    end
    for (int e = 0; e < 215; e++) begin
      n_cmp++;
      if (cap[e] !== exp_q[e]) begin
        n_bad++;
        $display("FAIL b2b e=%0d got %b want %b", e, cap[e], exp_q[e]);
      end
    end
  endtask

  task automatic test_overflow;
    int ovf_cnt;
    sched_w = '{0, 3, 4, 5, 6, 7};
    sched_v = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h3C};
    model(0, 215);
    run(0, 215);
    n_cmp++;
    if (cap[7][3] !== 1'b1 || cap[7][2:0] !== 3'd4) begin
      n_bad++;
      $display("FAIL ovf_pulse got ovf=%b lvl=%0d want 1 4", cap[7][3], cap[7][2:0]);
    end
    ovf_cnt = 0;
    for (int e = 0; e < 215; e++) if (cap[e][3] === 1'b1) ovf_cnt++;
    n_cmp++;
    if (ovf_cnt !== 1) begin
      n_bad++;
      $display("FAIL ovf_count got %0d want 1", ovf_cnt);
    end
    for (int e = 0; e < 215; e++) begin
      n_cmp++;
      if (cap[e] !== exp_q[e]) begin
        n_bad++;
        $display("FAIL ovf e=%0d got %b want %b", e, cap[e], exp_q[e]);
      end
    end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] v;
    sched_w = '{0};
    sched_v = '{8'hA5};
    run(0, 15);
    reset  = 1'b1;
    stb[0] = 1'b1;
    sd[0]  = 8'h55;
    @(posedge clk);
    @(negedge clk);
    reset  = 1'b0;
    stb[0] = 1'b0;
    n_cmp++;
    if ({txl[0], bsy[0], rdy[0], ovf[0], lvl[0]} !== 7'b1010000) begin
      n_bad++;
      $display("FAIL midreset got %b want 1010000", {txl[0], bsy[0], rdy[0], ovf[0], lvl[0]});
    end
    v = 8'($urandom);
    sched_w = '{2};
    sched_v = '{v};
    model(0, 50);
    run(0, 50);
    for (int e = 0; e < 50; e++) begin
      n_cmp++;
      if (cap[e] !== exp_q[e]) begin
        n_bad++;
        $display("FAIL midreset_frame e=%0d got %b want %b", e, cap[e], exp_q[e]);
      end
    end
  endtask

  task automatic test_5bit_2stop;
    sched_w = '{0};
    sched_v = '{8'h1F};
    model(3, 40);
    run(3, 40);
    n_cmp++;
    if (cap[1][6] !== 1'b0 || cap[5][6] !== 1'b1 || cap[32][5] !== 1'b1 || cap[33][5] !== 1'b0) begin
      n_bad++;
      $display("FAIL 5n2_shape got %b%b%b%b want 0110", cap[1][6], cap[5][6], cap[32][5], cap[33][5]);
    end
    for (int e = 0; e < 40; e++) begin
      n_cmp++;
      if (cap[e] !== exp_q[e]) begin
        n_bad++;
        $display("FAIL 5n2 e=%0d got %b want %b", e, cap[e], exp_q[e]);
      end
    end
  endtask

  task automatic test_random;
    int w, n;
    for (int i = 0; i < NI; i++) begin
      sched_w.delete();
      sched_v.delete();
      w = 0;
      for (int k = 0; k < 7; k++) begin
        sched_w.push_back(w);
        sched_v.push_back(8'($urandom));
        w += ($urandom_range(0, 3) == 0) ? 1 : int'($urandom_range(1, 50));
      end
      n = w + 7 * 44 + 10;
      model(i, n);
      run(i, n);
      for (int e = 0; e < n; e++) begin
        n_cmp++;
        if (cap[e] !== exp_q[e]) begin
          n_bad++;
          $display("FAIL random inst=%0d e=%0d got %b want %b", i, e, cap[e], exp_q[e]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_parity();
    test_back_to_back();
    test_overflow();
    test_reset_midframe();
    test_5bit_2stop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/raifes_uart_tx.md
RAIFES_UART_TX -- requirements
Module: raifes_uart_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 5208, meaning clock cycles per bit (50 MHz / 9600 Bd); legal range 2..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; legal range 5..8.
REQ-003 SHALL have parameter PARITY, default 0, meaning 0 none, 1 even, 2 odd.
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame; legal 1 or 2.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, meaning transmit FIFO entries; power of two, 2..16.
REQ-006 SHALL have port clk, input, 1, meaning single system clock; all logic on the rising edge.
REQ-007 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-008 SHALL have port sdata, input, DATA_BITS, meaning byte to enqueue.
REQ-009 SHALL have port send_strobe, input, 1, meaning one-cycle enqueue request.
REQ-010 SHALL have port ready, output, 1, meaning FIFO can accept a write this cycle.
REQ-011 SHALL have port busy, output, 1, meaning a frame is on the line or the FIFO is non-empty.
REQ-012 SHALL have port fifo_level, output, clog2(FIFO_DEPTH)+1, meaning current FIFO occupancy.
REQ-013 SHALL have port overflow, output, 1, meaning one-cycle pulse when a strobe is dropped.
REQ-014 SHALL have port UART_TX, output, 1, meaning serial line, idle high.

Function
REQ-015 SHALL accept a write when send_strobe=1 and ready=1; ready SHALL equal (fifo_level != FIFO_DEPTH).
REQ-016 SHALL drop a strobe arriving while ready=0, leave the FIFO unchanged, and pulse overflow high for exactly one cycle.
REQ-017 SHALL, on a simultaneous accepted write and pop, leave fifo_level unchanged.
REQ-018 SHALL preserve FIFO order, with pointers wrapping modulo FIFO_DEPTH.
REQ-019 SHALL implement the states IDLE, START, DATA, PAR, and STOP, all registered.
REQ-020 SHALL, in IDLE with the FIFO non-empty, pop one entry into the shift register and enter START on that edge.
REQ-021 SHALL drive UART_TX from a register: START=0; DATA=the current bit, LSB first; PAR=the parity bit; STOP=1; IDLE=1.
REQ-022 SHALL hold every bit for exactly CLK_DIV cycles, using a down-counter reloaded with CLK_DIV-1 on each bit boundary.
REQ-023 SHALL sequence START->DATA; DATA->PAR after DATA_BITS bits if PARITY!=0, else DATA->STOP; PAR->STOP; STOP->IDLE after STOP_BITS bits.
REQ-024 SHALL set the parity bit to the XOR of the data bits for PARITY=1 and to its inverse for PARITY=2.
REQ-025 SHALL, at the end of the last stop bit with the FIFO non-empty, go directly to START (0 idle cycles between frames).
REQ-026 SHALL give a latency of 2 edges: a write accepted at edge k into an empty FIFO in IDLE makes UART_TX fall after edge k+1.
REQ-027 SHALL give a frame length of CLK_DIV*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles.
REQ-028 SHALL treat sdata bits above DATA_BITS as non-existent (the port is exactly DATA_BITS wide).
REQ-029 SHALL map an illegal state encoding to IDLE on the next edge with UART_TX=1.

Reset
REQ-030 SHALL, with reset=1 at an edge, make UART_TX=1, state=IDLE, FIFO empty, fifo_level=0, ready=1, busy=0, overflow=0, and the bit counter reloaded.
REQ-031 SHALL abandon a frame in progress on reset; the line returns high after that edge, and entries written in the same cycle as reset are discarded.

Verification
REQ-032 SHALL be verified for a single byte: CLK_DIV=4, 8N1, write 0xA5 -> UART_TX = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; busy falls after 40 cycles.
REQ-033 SHALL be verified for parity: PARITY=1, write 0x07 -> parity bit 1; PARITY=2, write 0x07 -> parity bit 0; the frame is 11 bits.
REQ-034 SHALL be verified for back-to-back frames and a full FIFO: FIFO_DEPTH=4, write 5 bytes in consecutive cycles -> 5 frames with no idle gap between them and no overflow (first entry popped at edge k+1).
REQ-035 SHALL be verified for overflow: hold the line busy, fill the FIFO to 4, strobe 0x3C -> overflow pulses 1 cycle, fifo_level stays 4, and 0x3C is never transmitted.
REQ-036 SHALL be verified for reset mid-frame: assert reset during the data bits -> UART_TX=1, fifo_level=0, and ready=1 after the edge; a new write then transmits a complete, correct frame.
REQ-037 SHALL be verified for 5-bit, 2-stop-bit framing: DATA_BITS=5, STOP_BITS=2, write 0x1F -> start bit, five 1s, two stop bits, frame = 8*CLK_DIV cycles.
